// File: rtl/acq_sequencer.sv
// rtl/acq_sequencer.sv - start/stop run controller for the timetagger capture datapath
// All outputs are registered from next-state so they align with the state they describe.
module acq_sequencer #(
  parameter int STROBE_CH    = 4,
  parameter int DELTA_CH     = 4,
  parameter int RESET_CYCLES = 4,
  parameter int DUR_W        = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cmd_start,
  input  logic                 cmd_stop,
  input  logic [STROBE_CH-1:0] strobe_mask_in,
  input  logic [DELTA_CH-1:0]  delta_mask_in,
  input  logic [DUR_W-1:0]     duration,
  input  logic                 drain_idle,
  output logic [STROBE_CH-1:0] strobe_en,
  output logic [DELTA_CH-1:0]  delta_en,
  output logic                 counter_reset,
  output logic                 counter_run,
  output logic                 running,
  output logic                 busy,
  output logic                 done,
  output logic [DUR_W-1:0]     elapsed
);

  typedef enum logic [2:0] {
    S_IDLE, S_QUIESCE, S_RESET, S_RUN, S_DRAIN
  } state_e;

  localparam logic [7:0]       RST_LAST = 8'(RESET_CYCLES - 1);
  localparam logic [DUR_W-1:0] DUR_ONE  = {{(DUR_W-1){1'b0}}, 1'b1};

  state_e               state_q, state_d;
  logic [STROBE_CH-1:0] smask_q, smask_d, strobe_en_q, strobe_en_d;
  logic [DELTA_CH-1:0]  dmask_q, dmask_d, delta_en_q, delta_en_d;
  logic [DUR_W-1:0]     dur_q, dur_d, elapsed_q, elapsed_d;
  logic [7:0]           rst_cnt_q, rst_cnt_d;
  logic                 creset_q, creset_d, crun_q, crun_d;
  logic                 busy_q, busy_d, done_q, done_d;
  logic                 expire;

  always_comb begin
    state_d   = state_q;
    smask_d   = smask_q;
    dmask_d   = dmask_q;
    dur_d     = dur_q;
    elapsed_d = elapsed_q;
    rst_cnt_d = '0;
    // Timed expiry only considered for a bounded run
    expire    = (dur_q != '0) && (elapsed_q == (dur_q - DUR_ONE));

    case (state_q)
      S_IDLE: if (cmd_start && !cmd_stop) begin
        state_d = S_QUIESCE;
        smask_d = strobe_mask_in;
        dmask_d = delta_mask_in;
        dur_d   = duration;
      end
      S_QUIESCE: begin
        if (cmd_stop)        state_d = S_DRAIN;
        else if (drain_idle) state_d = S_RESET;
      end
      S_RESET: begin
        rst_cnt_d = rst_cnt_q + 8'd1;
        if (cmd_stop)                   state_d = S_DRAIN;
        else if (rst_cnt_q == RST_LAST) state_d = S_RUN;
      end
      S_RUN: if (cmd_stop || expire) state_d = S_DRAIN;
      S_DRAIN: if (drain_idle) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_RESET && state_q != S_RESET) begin
      elapsed_d = '0;
    end else if (state_q == S_RUN && state_d == S_RUN && elapsed_q != '1) begin
      elapsed_d = elapsed_q + DUR_ONE;
    end

    strobe_en_d = (state_d == S_RUN) ? smask_q : '0;
    delta_en_d  = (state_d == S_RUN) ? dmask_q : '0;
    creset_d    = (state_d == S_RESET);
    crun_d      = (state_d == S_RUN);
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_q == S_DRAIN) && (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      smask_q     <= '0;
      dmask_q     <= '0;
      dur_q       <= '0;
      elapsed_q   <= '0;
      rst_cnt_q   <= '0;
      strobe_en_q <= '0;
      delta_en_q  <= '0;
      creset_q    <= 1'b0;
      crun_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      smask_q     <= smask_d;
      dmask_q     <= dmask_d;
      dur_q       <= dur_d;
      elapsed_q   <= elapsed_d;
      rst_cnt_q   <= rst_cnt_d;
      strobe_en_q <= strobe_en_d;
      delta_en_q  <= delta_en_d;
      creset_q    <= creset_d;
      crun_q      <= crun_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign strobe_en     = strobe_en_q;
  assign delta_en      = delta_en_q;
  assign counter_reset = creset_q;
  assign counter_run   = crun_q;
  assign running       = crun_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign elapsed       = elapsed_q;

endmodule

// File: tb/tb_acq_sequencer.sv
// tb/tb_acq_sequencer.sv - directed self-checking bench for acq_sequencer
module tb_acq_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_start, cmd_stop, drain_idle;
  logic [3:0]  strobe_mask_in, delta_mask_in, strobe_en, delta_en;
  logic [31:0] duration, elapsed;
  logic        counter_reset, counter_run, running, busy, done;

  int n_checks = 0;
  int n_fail   = 0;

  acq_sequencer #(.STROBE_CH(4), .DELTA_CH(4), .RESET_CYCLES(4), .DUR_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_start(cmd_start), .cmd_stop(cmd_stop),
    .strobe_mask_in(strobe_mask_in), .delta_mask_in(delta_mask_in),
    .duration(duration), .drain_idle(drain_idle),
    .strobe_en(strobe_en), .delta_en(delta_en), .counter_reset(counter_reset),
    .counter_run(counter_run), .running(running), .busy(busy), .done(done),
    .elapsed(elapsed)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic start_cmd(input logic [3:0] sm, input logic [3:0] dm, input logic [31:0] dur);
    cmd_start = 1'b1; strobe_mask_in = sm; delta_mask_in = dm; duration = dur;
    @(negedge clk);
    cmd_start = 1'b0; strobe_mask_in = 4'h0; delta_mask_in = 4'h0; duration = 32'd0;
  endtask

  task automatic wait_running(input string tag);
    int ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (running) begin ok = 1; break; end
    end
    check(tag, ok, 1);
  endtask

  // Steps until a done pulse plus two quiet cycles; tallies what it saw on the way.
  task automatic watch(input int budget, output int run_n, output int cr_n, output int done_n,
                       output int gap, output logic [7:0] en_seen, output int viol);
    int last_run = -1, done_i = -1;
    run_n = 0; cr_n = 0; done_n = 0; gap = -1; en_seen = 8'h0; viol = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (running) begin run_n++; last_run = i; en_seen |= {strobe_en, delta_en}; end
      if (counter_reset) cr_n++;
      if (counter_reset && counter_run) viol++;
      if (running != counter_run) viol++;
      if (!running && {strobe_en, delta_en} != 8'h0) viol++;
      if (done) begin done_n++; done_i = i; gap = done_i - last_run; end
      if (done_n > 0 && i == done_i + 2) break;
    end
  endtask

  int run_n, cr_n, done_n, gap, viol, flag, cnt;
  logic [7:0] en_seen;

  initial begin
    reset_n = 1'b0; cmd_start = 1'b0; cmd_stop = 1'b0; drain_idle = 1'b1;
    strobe_mask_in = 4'h0; delta_mask_in = 4'h0; duration = 32'd0;
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    check("rst_busy", busy, 0);
    check("rst_outs", {strobe_en, delta_en, counter_reset, counter_run, running, done}, 0);
    check("rst_elapsed", elapsed, 0);

    // 1: unbounded run stopped after 100 cycles
    start_cmd(4'hF, 4'h0, 32'd0);
    check("t1_busy", busy, 1);
    check("t1_quiesce_cr", counter_reset, 0);
    flag = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (!counter_reset || counter_run || running) flag++;
    end
    check("t1_cr_4cyc", flag, 0);
    @(negedge clk);
    check("t1_cr_off", counter_reset, 0);
    check("t1_run", {running, counter_run}, 2'b11);
    check("t1_en", {strobe_en, delta_en}, 8'hF0);
    check("t1_el0", elapsed, 0);
    repeat (100) @(negedge clk);
    check("t1_el100", elapsed, 100);
    cmd_stop = 1'b1;
    @(negedge clk);
    cmd_stop = 1'b0;
    check("t1_drain_en", {strobe_en, delta_en, counter_run, running}, 0);
    check("t1_drain_busy", {busy, done}, 2'b10);
    @(negedge clk);
    check("t1_done", {busy, done}, 2'b01);
    check("t1_elapsed", elapsed, 100);
    @(negedge clk);
    check("t1_done_1cyc", done, 0);

    // 2: bounded run of 10
    start_cmd(4'hF, 4'h3, 32'd10);
    watch(60, run_n, cr_n, done_n, gap, en_seen, viol);
    check("t2_run_n", run_n, 10);
    check("t2_cr_n", cr_n, 4);
    check("t2_done_n", done_n, 1);
    check("t2_gap", gap, 2);
    check("t2_en", en_seen, 8'hF3);
    check("t2_viol", viol, 0);
    check("t2_elapsed", elapsed, 9);
    check("t2_idle", busy, 0);

    // 3: quiesce and drain held off by drain_idle
    drain_idle = 1'b0;
    start_cmd(4'h5, 4'hA, 32'd5);
    flag = 0;
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      if (counter_reset || !busy) flag++;
    end
    check("t3_quiesce_hold", flag, 0);
    drain_idle = 1'b1;
    @(negedge clk);
    check("t3_cr_after", counter_reset, 1);
    drain_idle = 1'b0;
    cnt = 0; flag = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (running) cnt++;
      if (cnt > 0 && !running) begin flag = 1; break; end
    end
    check("t3_run_n", cnt, 5);
    check("t3_in_drain", {flag[0], busy, counter_run}, 3'b110);
    flag = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done || !busy) flag++;
    end
    check("t3_drain_hold", flag, 0);
    drain_idle = 1'b1;
    @(negedge clk);
    check("t3_done", {busy, done}, 2'b01);
    check("t3_elapsed", elapsed, 4);

    // 4a: start and stop together
    cmd_start = 1'b1; cmd_stop = 1'b1; strobe_mask_in = 4'hF;
    @(negedge clk);
    cmd_start = 1'b0; cmd_stop = 1'b0;
    check("t4_both_busy", busy, 0);
    @(negedge clk);
    check("t4_both_busy2", busy, 0);

    // 4b: start during RUN does not disturb latched masks
    start_cmd(4'hF, 4'h3, 32'd0);
    wait_running("t4_wait_run");
    start_cmd(4'h1, 4'h8, 32'd2);
    check("t4_en_kept", {strobe_en, delta_en}, 8'hF3);
    repeat (3) @(negedge clk);
    check("t4_en_kept2", {strobe_en, running}, 5'h1F);
    cmd_stop = 1'b1;
    @(negedge clk);
    cmd_stop = 1'b0;
    watch(10, run_n, cr_n, done_n, gap, en_seen, viol);
    check("t4_stop_done", done_n, 1);

    // 4c: stop during RESET
    start_cmd(4'hF, 4'hF, 32'd0);
    @(negedge clk);
    check("t4c_cr", counter_reset, 1);
    cmd_stop = 1'b1;
    @(negedge clk);
    cmd_stop = 1'b0;
    check("t4c_cr_drop", {counter_reset, running, busy}, 3'b001);
    check("t4c_elapsed", elapsed, 0);
    @(negedge clk);
    check("t4c_done", {done, running}, 2'b10);

    // 5: reset mid-run
    start_cmd(4'hF, 4'hF, 32'd0);
    wait_running("t5_wait_run");
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("t5_outs", {strobe_en, delta_en, counter_reset, counter_run, running, busy, done}, 0);
    check("t5_elapsed", elapsed, 0);
    @(negedge clk);
    check("t5_no_done", {done, busy}, 0);
    start_cmd(4'h2, 4'h4, 32'd7);
    watch(60, run_n, cr_n, done_n, gap, en_seen, viol);
    check("t5_run_n", run_n, 7);
    check("t5_done_n", done_n, 1);
    check("t5_en", en_seen, 8'h24);
    check("t5_elapsed_end", elapsed, 6);

    // 6: duration 1, then stop coinciding with expiry
    start_cmd(4'h8, 4'h1, 32'd1);
    watch(60, run_n, cr_n, done_n, gap, en_seen, viol);
    check("t6_run_n", run_n, 1);
    check("t6_elapsed", elapsed, 0);
    check("t6_done_n", done_n, 1);
    start_cmd(4'hF, 4'hF, 32'd10);
    wait_running("t6_wait_run");
    repeat (9) @(negedge clk);
    check("t6_el9", elapsed, 9);
    cmd_stop = 1'b1;
    @(negedge clk);
    cmd_stop = 1'b0;
    check("t6_exit", {running, busy}, 2'b01);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) cnt++;
    end
    check("t6_one_done", cnt, 1);
    check("t6_final", {busy, elapsed}, {1'b0, 32'd9});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
